instruction_memory_loader: RTL and testbench
============================================

# instruction_memory_loader

Boot-time writer for the core's word-addressed instruction memory. It receives a framed byte stream from a serial receiver over a valid/ready byte handshake. It assembles little-endian 32-bit instruction words, writes them sequentially from word address 0, and verifies an 8-bit additive checksum. It holds the core in stall until a frame completes successfully.

## Interface
Parameters:
- `ADDR_WIDTH`, 11, word-address width; the memory holds 2^ADDR_WIDTH words (2048).
- `MAGIC`, 8'hA5, frame start byte.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx_valid`  in  1  byte available on `rx_data`.
- `rx_data`  in  8  received byte.
- `rx_ready`  out  1  loader can accept a byte. A byte transfers on an edge where `rx_valid && rx_ready`.
- `im_write_enable`  out  1  write request to instruction memory.
- `im_write_address`  out  ADDR_WIDTH  word address of the write.
- `im_write_data`  out  32  instruction word to write.
- `im_write_ready`  in  1  memory accepts the write on an edge where `im_write_enable && im_write_ready`.
- `core_hold`  out  1  stalls the core while 1.
- `load_done`  out  1  last frame loaded and checksum matched.
- `load_error`  out  1  last frame failed: bad checksum or oversize length.
- `words_loaded`  out  16  number of words written in the current or last frame.

## Operation
State machine states: IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERROR.

Frame format: MAGIC, then N[7:0], then N[15:8], then 4·N data bytes (LSB first per word), then SUM. SUM is the sum of all data bytes mod 256.

- **IDLE**
  - A non-MAGIC byte is accepted and discarded.
  - MAGIC → LEN_LO. This clears `words_loaded`, the checksum accumulator, and the byte counter.
- **LEN_LO**: the accepted byte is stored in N[7:0] → LEN_HI.
- **LEN_HI**: the accepted byte is stored in N[15:8].
  - N > 2^ADDR_WIDTH → ERROR.
  - N == 0 → CHECK.
  - Otherwise → DATA.
- **DATA**
  - Each accepted byte goes to byte lane `byte_cnt` (0..3) of the assembly register and is added into the 8-bit checksum. The sum wraps mod 256.
  - On the byte with `byte_cnt` == 3 → WRITE, with address = `words_loaded`[ADDR_WIDTH-1:0] and data = the assembled word.
- **WRITE**
  - `im_write_enable` = 1. Address and data are held stable; `rx_ready` = 0.
  - On the accepting edge, `words_loaded` increments.
  - Then → CHECK if the incremented count equals N, else → DATA.
- **CHECK**: one byte is accepted. It equals the checksum → DONE; otherwise → ERROR.
- **DONE / ERROR**
  - Both are sticky and behave like IDLE for input: non-MAGIC bytes are discarded.
  - MAGIC restarts a frame and clears `load_done` and `load_error`.
- `rx_ready` = 1 in every state except WRITE.
- `core_hold` = 0 only in DONE; it is 1 in all other states, including after reset.
- `load_done` = 1 only in DONE; `load_error` = 1 only in ERROR.
- No timeout exists. A truncated frame waits indefinitely; only reset recovers it.

## Timing
- All outputs are registered or decoded directly from the state register. There is no combinational path from `rx_*` to any output.
- Reset values:
  - State IDLE.
  - `rx_ready` = 1, `im_write_enable` = 0, `im_write_address` = 0, `im_write_data` = 0.
  - `core_hold` = 1, `load_done` = 0, `load_error` = 0, `words_loaded` = 0.
- A write is visible (`im_write_enable` = 1) in the cycle after the edge that accepted the 4th byte of the word.
- With `im_write_ready` held high, the WRITE state lasts 1 cycle. The minimum cost per word is 4 byte-accept cycles plus 1 write cycle.
- If `im_write_ready` = 0, the WRITE state extends with all outputs stable. No byte is accepted and none is lost.
- `load_done` and `core_hold` change in the cycle after the edge that accepted SUM. The same timing applies to the transition to ERROR after LEN_HI.
- Reset asserted mid-frame aborts immediately (asynchronously), with no partial write. Already-written words remain in memory.
- `words_loaded` reaching N == 2^ADDR_WIDTH is legal. The address wraps to 0 only after the final write, and that wrapped address is never used.

## Test plan
- **Reset:** assert `reset_n` = 0 mid-DATA, then release → all outputs at reset values, `core_hold` = 1, no `im_write_enable` pulse.
- **Good frame:** send A5 02 00, EF BE AD DE, 78 56 34 12, 4C → writes [0]=DEADBEEF and [1]=12345678, one cycle each. Then `load_done` = 1, `core_hold` = 0, `words_loaded` = 2.
- **Bad checksum:** send the same frame with SUM = 4D → both writes still occur, then `load_error` = 1, `load_done` = 0, `core_hold` = 1.
- **Back-pressure:** same frame with `im_write_ready` = 0 for 3 cycles on the first write → `im_write_enable`, address 0, and data DEADBEEF held 4 cycles; `rx_ready` = 0 throughout; no byte is dropped even with `rx_valid` held high; result is still DONE.
- **Length bounds:**
  - A5 01 08 (N = 0x0801) → ERROR after LEN_HI, no writes.
  - A5 00 00 00 → DONE, no writes.
  - A5 00 08 with 2048 words → the last write goes to address 7FF, then DONE.
- **Framing:** send 00 FF 12, then a good frame → the leading bytes are ignored and the frame loads. Then send a second frame A5 01 00 13 00 00 00 13 → `load_done` drops at the MAGIC byte, [0]=00000013 is written, and DONE is reached again.

Source files
------------

// File: rtl/instruction_memory_loader_if.sv
// Byte-stream receive, instruction-memory write and load-status signals of the boot loader.
// The loader itself connects through master; the receiver/memory/core side connects through slave.
interface instruction_memory_loader_if #(
   parameter int ADDR_WIDTH = 11
);
   logic                  rx_valid;
   logic [7:0]            rx_data;
   logic                  rx_ready;
   logic                  im_write_enable;
   logic [ADDR_WIDTH-1:0] im_write_address;
   logic [31:0]           im_write_data;
   logic                  im_write_ready;
   logic                  core_hold;
   logic                  load_done;
   logic                  load_error;
   logic [15:0]           words_loaded;

   modport master (
      input  rx_valid, rx_data, im_write_ready,
      output rx_ready, im_write_enable, im_write_address, im_write_data,
             core_hold, load_done, load_error, words_loaded
   );

   modport slave (
      output rx_valid, rx_data, im_write_ready,
      input  rx_ready, im_write_enable, im_write_address, im_write_data,
             core_hold, load_done, load_error, words_loaded
   );
endinterface

// File: rtl/instruction_memory_loader.sv
// Boot loader: parses MAGIC/length/data/SUM frames into little-endian words, writes them from
// address 0 and releases the core only after a frame whose additive checksum matches.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for MAGIC, other bytes discarded
// LEN_LO | next byte is N[7:0]
// LEN_HI | next byte is N[15:8], range-checked against memory size
// DATA   | assembling a word, byte_cnt selects the lane
// WRITE  | word presented to memory, receive paused
// CHECK  | next byte is compared with the running checksum
// DONE   | frame good, core released, MAGIC restarts
// ERROR  | frame bad, core held, MAGIC restarts
module instruction_memory_loader #(
   parameter int         ADDR_WIDTH = 11,
   parameter logic [7:0] MAGIC      = 8'hA5
) (
   input logic                        clk,
   input logic                        reset_n,
   instruction_memory_loader_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
      S_WRITE,
      S_CHECK,
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

   state_t      state_q, state_d;
   logic [15:0] len_q, len_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [7:0]  sum_q, sum_d;
   logic [31:0] word_q, word_d;
   logic [15:0] words_loaded_q, words_loaded_d;
   logic        accept;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= S_IDLE;
         len_q          <= '0;
         byte_cnt_q     <= '0;
         sum_q          <= '0;
         word_q         <= '0;
         words_loaded_q <= '0;
      end else begin
         state_q        <= state_d;
         len_q          <= len_d;
         byte_cnt_q     <= byte_cnt_d;
         sum_q          <= sum_d;
         word_q         <= word_d;
         words_loaded_q <= words_loaded_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      len_d          = len_q;
      byte_cnt_d     = byte_cnt_q;
      sum_d          = sum_q;
      word_d         = word_q;
      words_loaded_d = words_loaded_q;
      accept         = bus.rx_valid && (state_q != S_WRITE);

      unique case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (accept && (bus.rx_data == MAGIC)) begin
               state_d        = S_LEN_LO;
               words_loaded_d = '0;
               sum_d          = '0;
               byte_cnt_d     = '0;
            end
         end
         S_LEN_LO: begin
            if (accept) begin
               len_d[7:0] = bus.rx_data;
               state_d    = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (accept) begin
               len_d[15:8] = bus.rx_data;
               if ({1'b0, len_d} > MAX_WORDS) begin
                  state_d = S_ERROR;
               end else if (len_d == 16'd0) begin
                  state_d = S_CHECK;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (accept) begin
               word_d[{byte_cnt_q, 3'b000} +: 8] = bus.rx_data;
               sum_d      = sum_q + bus.rx_data;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  state_d = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            // The count reaching 2^ADDR_WIDTH wraps the address to 0, but CHECK follows so it is never used.
            if (bus.im_write_ready) begin
               words_loaded_d = words_loaded_q + 16'd1;
               state_d        = (words_loaded_d == len_q) ? S_CHECK : S_DATA;
            end
         end
         S_CHECK: begin
            if (accept) begin
               state_d = (bus.rx_data == sum_q) ? S_DONE : S_ERROR;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.rx_ready         = (state_q != S_WRITE);
   assign bus.im_write_enable  = (state_q == S_WRITE);
   assign bus.im_write_address = words_loaded_q[ADDR_WIDTH-1:0];
   assign bus.im_write_data    = word_q;
   assign bus.core_hold        = (state_q != S_DONE);
   assign bus.load_done        = (state_q == S_DONE);
   assign bus.load_error       = (state_q == S_ERROR);
   assign bus.words_loaded     = words_loaded_q;

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Randomised frame bench for instruction_memory_loader: a frame-level model predicts the write
// sequence and final status, and a per-cycle monitor checks every presented write against it.
module tb_instruction_memory_loader;
   localparam int AW    = 11;
   localparam int DEPTH = 1 << AW;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   instruction_memory_loader_if #(.ADDR_WIDTH(AW)) bus ();

   instruction_memory_loader #(.ADDR_WIDTH(AW), .MAGIC(8'hA5)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;

   int          exp_addr[$];
   logic [31:0] exp_data[$];
   logic        exp_done, exp_err;
   int          exp_words;
   logic [7:0]  tx[$];

   int rdy_mode = 0;
   int stall_left = 0;
   int run_len = 0;
   int runs[$];

   logic [7:0] gf[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic logic [7:0] model_sum(input logic [31:0] w0, input logic [31:0] w1);
      int total = 0;
      for (int k = 0; k < 4; k++) total += int'(w0[8*k +: 8]) + int'(w1[8*k +: 8]);
      return 8'(total % 256);
   endfunction

   function automatic logic [31:0] pack(input logic [7:0] b0, input logic [7:0] b1,
                                        input logic [7:0] b2, input logic [7:0] b3);
      return {b3, b2, b1, b0};
   endfunction

   // Frame-level model: what bytes go on the wire and what the loader must do with them.
   task automatic make_frame(input int n, input bit bad, input int garbage);
      logic [7:0]  b;
      logic [31:0] w;
      int          total;
      for (int g = 0; g < garbage; g++) begin
         b = 8'($urandom_range(0, 255));
         if (b == 8'hA5) b = 8'h00;
         tx.push_back(b);
      end
      tx.push_back(8'hA5);
      tx.push_back(8'(n));
      tx.push_back(8'(n >> 8));
      if (n > DEPTH) begin
         exp_done = 1'b0; exp_err = 1'b1; exp_words = 0;
         return;
      end
      total = 0;
      for (int i = 0; i < n; i++) begin
         w = $urandom;
         for (int k = 0; k < 4; k++) begin
            tx.push_back(w[8*k +: 8]);
            total += int'(w[8*k +: 8]);
         end
         exp_addr.push_back(i % DEPTH);
         exp_data.push_back(w);
      end
      tx.push_back(bad ? 8'((total + $urandom_range(1, 255)) % 256) : 8'(total % 256));
      exp_done = !bad; exp_err = bad; exp_words = n;
   endtask

   task automatic expect_good_lit(input logic [7:0] sum_byte);
      exp_addr.push_back(0); exp_data.push_back(32'hDEADBEEF);
      exp_addr.push_back(1); exp_data.push_back(32'h12345678);
      exp_done = (sum_byte == 8'h4C); exp_err = (sum_byte != 8'h4C); exp_words = 2;
   endtask

   // Called and returns at posedge+1; rx_valid stays high across back-to-back calls.
   task automatic send_byte(input logic [7:0] b);
      bit rdy;
      int budget;
      budget = 200;
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      do begin
         @(negedge clk);
         rdy = bus.rx_ready;
         @(posedge clk);
         #1;
         budget--;
      end while (!rdy && budget > 0);
      chk("byte_accepted", 32'(rdy), 32'd1);
      bus.rx_valid = 1'b0;
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input int gap_max);
      logic [7:0] b;
      while (tx.size() > 0) begin
         b = tx.pop_front();
         repeat ($urandom_range(0, gap_max)) idle_cycle();
         send_byte(b);
      end
      @(negedge clk);
      chk("load_done", 32'(bus.load_done), 32'(exp_done));
      chk("load_error", 32'(bus.load_error), 32'(exp_err));
      chk("core_hold", 32'(bus.core_hold), 32'(!exp_done));
      chk("words_loaded", 32'(bus.words_loaded), 32'(exp_words));
      chk("writes_pending", 32'(exp_addr.size()), 32'd0);
      idle_cycle();
   endtask

   task automatic check_reset_values();
      chk("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
      chk("rst_we", 32'(bus.im_write_enable), 32'd0);
      chk("rst_addr", 32'(bus.im_write_address), 32'd0);
      chk("rst_data", bus.im_write_data, 32'd0);
      chk("rst_hold", 32'(bus.core_hold), 32'd1);
      chk("rst_done", 32'(bus.load_done), 32'd0);
      chk("rst_error", 32'(bus.load_error), 32'd0);
      chk("rst_words", 32'(bus.words_loaded), 32'd0);
   endtask

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0: bus.im_write_ready = 1'b1;
         1: bus.im_write_ready = ($urandom_range(0, 3) != 0);
         default: begin
            if (bus.im_write_enable && stall_left > 0) begin
               bus.im_write_ready = 1'b0;
               stall_left--;
            end else begin
               bus.im_write_ready = 1'b1;
            end
         end
      endcase
   end

   // Every cycle: each presented write must be the next one the model predicts, held until accepted.
   always @(negedge clk) begin
      if (reset_n) begin
         chk("rx_ready_vs_write", 32'(bus.rx_ready), 32'(!bus.im_write_enable));
         chk("hold_vs_done", 32'(bus.core_hold), 32'(!bus.load_done));
         if (bus.im_write_enable) begin
            run_len++;
            chk("write_expected", 32'(exp_addr.size() != 0), 32'd1);
            if (exp_addr.size() != 0) begin
               chk("write_addr", 32'(bus.im_write_address), 32'(exp_addr[0]));
               chk("write_data", bus.im_write_data, exp_data[0]);
               if (bus.im_write_ready) begin
                  void'(exp_addr.pop_front());
                  void'(exp_data.pop_front());
               end
            end
         end else if (run_len > 0) begin
            runs.push_back(run_len);
            run_len = 0;
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      gf = '{8'hA5, 8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12, 8'h4C};
      bus.rx_valid = 1'b0;
      bus.rx_data = 8'h00;
      bus.im_write_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      check_reset_values();
      idle_cycle();

      chk("pin_model_sum", 32'(model_sum(32'hDEADBEEF, 32'h12345678)), 32'h4C);
      chk("pin_pack", pack(8'hEF, 8'hBE, 8'hAD, 8'hDE), 32'hDEADBEEF);

      // good frame, with the first write checked in the cycle after its 4th byte
      expect_good_lit(8'h4C);
      for (int i = 0; i < 7; i++) send_byte(gf[i]);
      @(negedge clk);
      chk("first_write_visible", 32'(bus.im_write_enable), 32'd1);
      chk("first_write_addr", 32'(bus.im_write_address), 32'd0);
      chk("first_write_data", bus.im_write_data, 32'hDEADBEEF);
      idle_cycle();
      for (int i = 7; i < 12; i++) tx.push_back(gf[i]);
      send_frame(0);

      // bad checksum
      expect_good_lit(8'h4D);
      for (int i = 0; i < 11; i++) tx.push_back(gf[i]);
      tx.push_back(8'h4D);
      send_frame(1);

      // back-pressure on the first write, rx_valid held high throughout
      rdy_mode = 2; stall_left = 3; runs.delete();
      expect_good_lit(8'h4C);
      for (int i = 0; i < 12; i++) tx.push_back(gf[i]);
      send_frame(0);
      chk("bp_first_write_cycles", 32'((runs.size() > 0) ? runs[0] : 0), 32'd4);
      rdy_mode = 0;

      // length bounds
      make_frame(16'h0801, 1'b0, 0);
      send_frame(0);
      make_frame(0, 1'b0, 0);
      send_frame(0);
      make_frame(DEPTH, 1'b0, 0);
      send_frame(0);

      // framing: leading junk, then a restart from DONE
      tx.push_back(8'h00); tx.push_back(8'hFF); tx.push_back(8'h12);
      expect_good_lit(8'h4C);
      for (int i = 0; i < 12; i++) tx.push_back(gf[i]);
      send_frame(0);
      exp_addr.push_back(0); exp_data.push_back(32'h00000013);
      exp_done = 1'b1; exp_err = 1'b0; exp_words = 1;
      send_byte(8'hA5);
      @(negedge clk);
      chk("done_drops_at_magic", 32'(bus.load_done), 32'd0);
      chk("hold_at_magic", 32'(bus.core_hold), 32'd1);
      idle_cycle();
      tx.push_back(8'h01); tx.push_back(8'h00); tx.push_back(8'h13); tx.push_back(8'h00);
      tx.push_back(8'h00); tx.push_back(8'h00); tx.push_back(8'h13);
      send_frame(0);

      // random frames
      for (int f = 0; f < 10; f++) begin
         rdy_mode = $urandom_range(0, 1);
         make_frame((f == 4) ? $urandom_range(DEPTH + 1, 65535) : $urandom_range(0, 12),
                    ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
         send_frame($urandom_range(0, 2));
      end
      rdy_mode = 0;

      // reset mid-DATA aborts without a write
      make_frame(2, 1'b0, 0);
      for (int i = 0; i < 6; i++) send_byte(tx.pop_front());
      #3 reset_n = 1'b0;
      exp_addr.delete(); exp_data.delete(); tx.delete();
      run_len = 0;
      #1;
      check_reset_values();
      @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      chk("post_reset_we", 32'(bus.im_write_enable), 32'd0);
      chk("post_reset_hold", 32'(bus.core_hold), 32'd1);
      idle_cycle();
      make_frame(3, 1'b0, 1);
      send_frame(1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
